// File: rtl/channel_reader.sv
// channel_reader: round-robin drain of the per-channel timestamp FIFOs.
// Each served channel produces a framed byte stream on a valid/ready port.
// A data frame is a header byte followed by the 64-bit FIFO word, LSB first.
// An overrun frame is the header byte alone, followed by a clear pulse.
module channel_reader #(
   parameter int NCHAN   = 4,
   parameter int HOLDOFF = 3
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [NCHAN-1:0]   attention,
   input  logic [NCHAN-1:0]   overrun,
   input  logic [8*NCHAN-1:0] chandata,
   output logic [2:0]         byteaddr,
   output logic [NCHAN-1:0]   unload,
   output logic [NCHAN-1:0]   clearoverrun,
   output logic [7:0]         txdata,
   output logic               txvalid,
   input  logic               txready,
   output logic               busy
);

   localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   typedef enum logic [2:0] {
      ST_SCAN,
      ST_HDR,
      ST_LOAD,
      ST_SEND,
      ST_UNLOAD,
      ST_CLEAR,
      ST_HOLD
   } state_t;

   state_t        state_reg, state_next;
   // grant_reg is also the round-robin pointer: the next search starts one past it.
   logic [CW-1:0] grant_reg, grant_next;
   logic          ovf_reg, ovf_next;
   logic [2:0]    k_reg, k_next;
   logic [HW-1:0] hold_reg, hold_next;
   logic [7:0]    txdata_reg, txdata_next;
   logic          txvalid_reg, txvalid_next;
   logic          unload_reg, unload_next;
   logic          clear_reg, clear_next;

   logic          found;
   logic [CW-1:0] pick;
   logic [2:0]    pick_id;
   logic [4:0]    idx_sum;
   logic [7:0]    chan_byte [NCHAN];

   // Per-channel byte slices and the one-hot decode of the pulse outputs.
   // The pulses are decoded from the held grant, so at most one bit is ever set.
   generate
      for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
         assign chan_byte[gi]    = chandata[8*gi +: 8];
         assign unload[gi]       = unload_reg && (grant_reg == CW'(gi));
         assign clearoverrun[gi] = clear_reg  && (grant_reg == CW'(gi));
      end
   endgenerate

   assign pick_id  = 3'(pick);
   assign byteaddr = k_reg;
   assign txdata   = txdata_reg;
   assign txvalid  = txvalid_reg;
   assign busy     = (state_reg != ST_SCAN);

   // Round-robin search: the first channel with attention, starting one past the last grant.
   always_comb begin
      found   = 1'b0;
      pick    = grant_reg;
      idx_sum = '0;
      for (int i = 0; i < NCHAN; i++) begin
         idx_sum = 5'(grant_reg) + 5'(i) + 5'd1;
         if (idx_sum >= 5'(NCHAN)) begin
            idx_sum = idx_sum - 5'(NCHAN);
         end
         if (!found && attention[idx_sum[CW-1:0]]) begin
            found = 1'b1;
            pick  = idx_sum[CW-1:0];
         end
      end
   end

   // Next-state and next-output logic; the outputs are all registered from these values.
   always_comb begin
      state_next   = state_reg;
      grant_next   = grant_reg;
      ovf_next     = ovf_reg;
      k_next       = k_reg;
      hold_next    = hold_reg;
      txdata_next  = txdata_reg;
      txvalid_next = 1'b0;
      unload_next  = 1'b0;
      clear_next   = 1'b0;
      case (state_reg)
         ST_SCAN: begin
            if (found) begin
               // The overrun flag is sampled in the grant cycle and fixes the frame type.
               grant_next   = pick;
               ovf_next     = overrun[pick];
               txdata_next  = {overrun[pick], 4'b0000, pick_id};
               txvalid_next = 1'b1;
               state_next   = ST_HDR;
            end
         end
         ST_HDR: begin
            txvalid_next = 1'b1;
            if (txready) begin
               txvalid_next = 1'b0;
               if (ovf_reg) begin
                  // Overrun frames carry no payload; the FIFO word waits for the next service.
                  clear_next = 1'b1;
                  state_next = ST_CLEAR;
               end else begin
                  k_next     = 3'd0;
                  state_next = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            // byteaddr has been stable for this whole cycle, so the mux output is settled.
            txdata_next  = chan_byte[grant_reg];
            txvalid_next = 1'b1;
            state_next   = ST_SEND;
         end
         ST_SEND: begin
            txvalid_next = 1'b1;
            if (txready) begin
               txvalid_next = 1'b0;
               if (k_reg == 3'd7) begin
                  k_next      = 3'd0;
                  unload_next = 1'b1;
                  state_next  = ST_UNLOAD;
               end else begin
                  k_next     = k_reg + 3'd1;
                  state_next = ST_LOAD;
               end
            end
         end
         ST_UNLOAD, ST_CLEAR: begin
            hold_next  = HW'(HOLDOFF - 1);
            state_next = ST_HOLD;
         end
         ST_HOLD: begin
            // Give the channel's registered attention time to reflect the pop or clear.
            if (hold_reg == '0) begin
               state_next = ST_SCAN;
            end else begin
               hold_next = hold_reg - HW'(1);
            end
         end
         default: begin
            state_next = ST_SCAN;
         end
      endcase
   end

   // State and output registers; reset abandons any partial frame without an unload.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg   <= ST_SCAN;
         grant_reg   <= CW'(NCHAN - 1);
         ovf_reg     <= 1'b0;
         k_reg       <= 3'd0;
         hold_reg    <= '0;
         txdata_reg  <= 8'h00;
         txvalid_reg <= 1'b0;
         unload_reg  <= 1'b0;
         clear_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         grant_reg   <= grant_next;
         ovf_reg     <= ovf_next;
         k_reg       <= k_next;
         hold_reg    <= hold_next;
         txdata_reg  <= txdata_next;
         txvalid_reg <= txvalid_next;
         unload_reg  <= unload_next;
         clear_reg   <= clear_next;
      end
   end

endmodule

// File: tb/tb_channel_reader.sv
// Directed bench for channel_reader with a behavioural model of four channels.
// Each channel has a 4-deep FIFO, a latched overrun flag, registered attention and a byte mux.
module tb_channel_reader;

   localparam int NCH   = 4;
   localparam int HOLD  = 3;
   localparam int DEPTH = 4;
   localparam logic [63:0] STEP = 64'h0001_0000_0000_0001;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             txready = 1'b1;
   logic [NCH-1:0]   attention;
   logic [NCH-1:0]   overrun;
   logic [8*NCH-1:0] chandata;
   logic [2:0]       byteaddr;
   logic [NCH-1:0]   unload;
   logic [NCH-1:0]   clearoverrun;
   logic [7:0]       txdata;
   logic             txvalid;
   logic             busy;

   always #5 clk = ~clk;

   channel_reader #(.NCHAN(NCH), .HOLDOFF(HOLD)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .attention    (attention),
      .overrun      (overrun),
      .chandata     (chandata),
      .byteaddr     (byteaddr),
      .unload       (unload),
      .clearoverrun (clearoverrun),
      .txdata       (txdata),
      .txvalid      (txvalid),
      .txready      (txready),
      .busy         (busy)
   );

   // ---------------- channel model ----------------
   int             cnt_q [NCH] = '{default: 0};
   int             rp_q  [NCH] = '{default: 0};
   int             cnt_n [NCH];
   int             rp_n  [NCH];
   logic [NCH-1:0] ovf_q  = '0;
   logic [NCH-1:0] attn_q = '0;
   logic [NCH-1:0] ovf_n;
   logic [63:0]    mem_q [NCH][DEPTH];
   logic [63:0]    mem_n [NCH][DEPTH];
   logic [NCH-1:0] push_mask = '0;
   int             push_n = 0;
   logic [63:0]    push_base = 64'h0;

   assign attention = attn_q;
   assign overrun   = ovf_q;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         chandata[8*c +: 8] = 8'(mem_q[c][rp_q[c]] >> {byteaddr, 3'b000});
      end
   end

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         cnt_n[c] = cnt_q[c];
         rp_n[c]  = rp_q[c];
         ovf_n[c] = ovf_q[c];
         for (int d = 0; d < DEPTH; d++) mem_n[c][d] = mem_q[c][d];
         if (unload[c] && cnt_q[c] != 0) begin
            rp_n[c]  = (rp_q[c] + 1) % DEPTH;
            cnt_n[c] = cnt_q[c] - 1;
         end
         if (clearoverrun[c]) ovf_n[c] = 1'b0;
         if (push_mask[c]) begin
            for (int i = 0; i < 8; i++) begin
               if (i < push_n) begin
                  if (cnt_n[c] < DEPTH) begin
                     mem_n[c][(rp_n[c] + cnt_n[c]) % DEPTH] = push_base + 64'(i) * STEP;
                     cnt_n[c] = cnt_n[c] + 1;
                  end else begin
                     ovf_n[c] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) attn_q[c] <= (cnt_q[c] != 0) || ovf_q[c];
      cnt_q <= cnt_n;
      rp_q  <= rp_n;
      ovf_q <= ovf_n;
      mem_q <= mem_n;
   end

   // ---------------- monitor ----------------
   logic [7:0]     rx_q [$];
   int             rx_cyc [$];
   logic [NCH-1:0] un_q [$];
   int             un_cyc [$];
   logic [NCH-1:0] cl_q [$];
   int             cyc = 0;
   int             stab_err = 0;
   int             excl_err = 0;
   logic           pend_v = 1'b0;
   logic [7:0]     pend_d = 8'h00;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rstn) begin
         pend_v <= 1'b0;
      end else begin
         if (pend_v && (!txvalid || txdata != pend_d)) stab_err <= stab_err + 1;
         pend_v <= txvalid && !txready;
         pend_d <= txdata;
         if (txvalid && txready) begin
            rx_q.push_back(txdata);
            rx_cyc.push_back(cyc);
         end
         if (unload != '0) begin
            un_q.push_back(unload);
            un_cyc.push_back(cyc);
         end
         if (clearoverrun != '0) cl_q.push_back(clearoverrun);
         if (($countones(unload) + $countones(clearoverrun)) > 1) excl_err <= excl_err + 1;
      end
   end

   // ---------------- checking helpers ----------------
   int         n_pass = 0;
   int         n_total = 0;
   logic [7:0] exp_q [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [NCH-1:0] mask, input int n, input logic [63:0] base);
      push_mask = mask;
      push_n    = n;
      push_base = base;
      tick(1);
      push_mask = '0;
   endtask

   task automatic add_frame(input logic [7:0] hdr, input logic [63:0] w);
      exp_q.push_back(hdr);
      for (int b = 0; b < 8; b++) exp_q.push_back(w[8*b +: 8]);
   endtask

   task automatic check_bytes(input string tag, input int start);
      chk({tag, " count"}, 64'(rx_q.size() - start), 64'(exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) begin
         if (start + j < rx_q.size())
            chk($sformatf("%s byte%0d", tag, j), 64'(rx_q[start + j]), 64'(exp_q[j]));
      end
      exp_q.delete();
   endtask

   task automatic run_until(input int target, input int budget, input bit rnd, input string tag);
      int k;
      k = 0;
      while (un_q.size() < target && k < budget) begin
         txready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick(1);
         k++;
      end
      txready = 1'b1;
      chk({tag, " done"}, 64'(un_q.size() >= target), 64'd1);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, " byteaddr"}, 64'(byteaddr), 64'd0);
      chk({tag, " unload"}, 64'(unload), 64'd0);
      chk({tag, " clearoverrun"}, 64'(clearoverrun), 64'd0);
      chk({tag, " txdata"}, 64'(txdata), 64'h00);
      chk({tag, " txvalid"}, 64'(txvalid), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   logic [7:0] se_bytes [9] = '{8'h02, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
   logic [3:0] rr_hdr [6] = '{4'd0, 4'd1, 4'd3, 4'd0, 4'd1, 4'd3};
   int s0, u0, c0, k;
   logic [63:0] b1, b2, b3, b4;

   initial begin
      b1 = 64'hA5A5_0000_1111_2222;
      b2 = 64'h5A00_C0DE_0000_0010;
      b3 = 64'h3C3C_7E7E_9999_0F0E;
      b4 = 64'h1122_3344_5566_7788;

      // Reset state
      tick(3);
      check_quiet("reset");
      rstn = 1'b1;
      tick(5);

      // Single event on channel 2
      s0 = rx_q.size();
      u0 = un_q.size();
      push(4'b0100, 1, 64'h0123_4567_89AB_CDEF);
      run_until(u0 + 1, 200, 1'b0, "single");
      tick(40);
      foreach (se_bytes[i]) exp_q.push_back(se_bytes[i]);
      check_bytes("single", s0);
      chk("single unload count", 64'(un_q.size() - u0), 64'd1);
      chk("single unload value", 64'(un_q[u0]), 64'b0100);
      chk("single unload latency", 64'(un_cyc[u0] - rx_cyc[s0]), 64'd17);
      chk("single idle busy", 64'(busy), 64'd0);
      chk("single idle txvalid", 64'(txvalid), 64'd0);

      // Round-robin after a fresh reset
      rstn = 1'b0;
      tick(2);
      rstn = 1'b1;
      tick(2);
      s0 = rx_q.size();
      u0 = un_q.size();
      push(4'b1011, 2, b1);
      run_until(u0 + 6, 600, 1'b0, "rr");
      tick(40);
      for (int f = 0; f < 6; f++) add_frame({4'h0, rr_hdr[f]}, (f < 3) ? b1 : b1 + STEP);
      check_bytes("rr", s0);
      chk("rr unload count", 64'(un_q.size() - u0), 64'd6);
      for (int f = 0; f < 6; f++)
         chk($sformatf("rr unload%0d", f), 64'(un_q[u0 + f]), 64'(4'b0001 << rr_hdr[f]));
      chk("rr header spacing", 64'(rx_cyc[s0 + 9] - rx_cyc[s0]), 64'd22);

      // Overrun on channel 1: four words fit, the fifth sets the flag
      s0 = rx_q.size();
      u0 = un_q.size();
      c0 = cl_q.size();
      push(4'b0010, 5, b2);
      run_until(u0 + 4, 800, 1'b0, "ovr");
      tick(40);
      exp_q.push_back(8'h81);
      for (int w = 0; w < 4; w++) add_frame(8'h01, b2 + 64'(w) * STEP);
      check_bytes("ovr", s0);
      chk("ovr clear count", 64'(cl_q.size() - c0), 64'd1);
      chk("ovr clear value", 64'(cl_q[c0]), 64'b0010);
      chk("ovr unload count", 64'(un_q.size() - u0), 64'd4);

      // Backpressure with random txready on channel 0
      s0 = rx_q.size();
      u0 = un_q.size();
      push(4'b0001, 2, b3);
      run_until(u0 + 2, 2000, 1'b1, "bp");
      tick(40);
      add_frame(8'h00, b3);
      add_frame(8'h00, b3 + STEP);
      check_bytes("bp", s0);
      chk("bp hold stability", 64'(stab_err), 64'd0);

      // Reset after the byte-3 transfer on channel 3
      s0 = rx_q.size();
      u0 = un_q.size();
      push(4'b1000, 1, b4);
      k = 0;
      while (rx_q.size() < s0 + 5 && k < 200) begin
         tick(1);
         k++;
      end
      chk("midrst reach byte3", 64'(rx_q.size() >= s0 + 5), 64'd1);
      rstn = 1'b0;
      #1;
      check_quiet("midrst in reset");
      tick(2);
      chk("midrst no unload", 64'(un_q.size() - u0), 64'd0);
      s0 = rx_q.size();
      rstn = 1'b1;
      run_until(u0 + 1, 300, 1'b0, "midrst");
      tick(40);
      add_frame(8'h03, b4);
      check_bytes("midrst", s0);
      chk("midrst unload count", 64'(un_q.size() - u0), 64'd1);
      chk("midrst unload value", 64'(un_q[u0]), 64'b1000);

      // Idle with all channels drained
      s0 = rx_q.size();
      u0 = un_q.size();
      tick(50);
      chk("idle no bytes", 64'(rx_q.size() - s0), 64'd0);
      chk("idle no unload", 64'(un_q.size() - u0), 64'd0);
      chk("idle busy", 64'(busy), 64'd0);
      chk("idle txvalid", 64'(txvalid), 64'd0);
      chk("pulse exclusivity", 64'(excl_err), 64'd0);
      chk("stability overall", 64'(stab_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/channel_reader.md
# channel_reader

Drains the timestamp channels toward the host. Round-robin scans the per-channel `attention` lines, reads each pending 64-bit FIFO word one byte at a time through the shared byte-address mux, and streams it as a framed byte sequence over a valid/ready interface to the host serializer. Pulses `unload` after a word is sent, and reports and clears overrun conditions with `clearoverrun`.

## Interface

Parameters:
- `NCHAN`, default 4: number of channels, 1..8.
- `HOLDOFF`, default 3: cycles to wait after an `unload` or `clearoverrun` pulse before `attention` is sampled again. Minimum 3.

Ports:
- `clk`  in  1  single clock, shared with the channels.
- `rstn`  in  1  reset; asynchronous, active-low.
- `attention`  in  NCHAN  per-channel attention, registered inside each channel.
- `overrun`  in  NCHAN  per-channel latched overrun flag.
- `chandata`  in  8*NCHAN  per-channel mux output byte; channel n is `[8n+7:8n]`.
- `byteaddr`  out  3  byte select, driven to all channels.
- `unload`  out  NCHAN  one-cycle pulse that pops the granted channel's FIFO.
- `clearoverrun`  out  NCHAN  one-cycle pulse that clears the granted channel's overrun flag.
- `txdata`  out  8  outgoing byte.
- `txvalid`  out  1  `txdata` is valid.
- `txready`  in  1  the sink accepts the byte.
- `busy`  out  1  high in every state except SCAN.

## Operation

- State machine: SCAN → HDR → (LOAD → SEND)×8 → UNLOAD → HOLD → SCAN. An overrun path runs SCAN → HDR → CLEAR → HOLD → SCAN.
- **SCAN**
  - Grant the first channel with `attention` high, searching from (last granted + 1) mod NCHAN.
  - After reset the search starts at channel 0.
  - If no channel has `attention`, stay in SCAN.
  - The grant index is registered and held until HOLD exits.
- **HDR**
  - The header byte is `{ovf, 4'b0000, chan[2:0]}`.
  - `ovf` is the granted channel's `overrun` value, sampled in the SCAN cycle.
  - If `ovf`=1, go to CLEAR after the header transfer. No payload is sent; the FIFO word stays for the next service.
  - If `ovf`=0, go to LOAD with byte index k=0.
- **LOAD:** drive `byteaddr`=k and wait one cycle for the mux to settle.
- **SEND**
  - Register `txdata` from the granted channel's `chandata` slice and hold it.
  - Advance on transfer: k++, return to LOAD; after k=7, go to UNLOAD.
  - Bytes go out LSB first. Bit 0 of byte 0 is the input level; the upper 63 bits are the counter.
- **UNLOAD:** one-cycle `unload[grant]`=1, then HOLD.
- **CLEAR:** one-cycle `clearoverrun[grant]`=1, then HOLD.
- **HOLD:** wait HOLDOFF cycles so the delayed `attention` reflects the new FIFO/overrun state, then SCAN.
- At most one bit of `unload` or `clearoverrun` is high in any cycle, and never both.
- A channel's `attention` changing while it is not granted has no effect on the current frame.

## Timing

- Reset values: `byteaddr`=0, `unload`=0, `clearoverrun`=0, `txdata`=8'h00, `txvalid`=0, `busy`=0, state=SCAN, last-grant pointer = NCHAN-1.
- Handshake rules:
  - A transfer happens on a rising `clk` edge with `txvalid`&`txready`.
  - While `txvalid`=1 and no transfer has occurred, `txdata` is stable and `txvalid` does not drop.
  - `txvalid` never depends combinationally on `txready`.
  - `txvalid` is 0 in LOAD, UNLOAD, CLEAR, HOLD and SCAN.
- Latency, with `txready` tied to 1:
  - Header `txvalid` is asserted the cycle after the SCAN grant.
  - Each payload byte takes 2 cycles.
  - `unload` fires 1 cycle after the byte-7 transfer.
  - A data frame takes 1 + 1 + 16 + 1 + HOLDOFF cycles from grant to the next SCAN: 22 at the default.
- Backpressure: with `txready` low, the FSM stalls in HDR or SEND indefinitely, with no timeout.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned, with no `unload`, so the word is re-sent in full after reset.

## Test plan

- **Single event:** one channel (NCHAN=4), ch2 receives one edge with counter = 64'h0123_4567_89AB_CDEF>>1 and level 1. Required response:
  - Bytes 8'h02, EF, CD, AB, 89, 67, 45, 23, 01 are sent.
  - One `unload`=4'b0100 pulse follows.
  - No second frame is sent.
- **Round-robin:** ch0, ch1 and ch3 each hold 2 words → grant order 0, 1, 3, 0, 1, 3; six frames, six `unload` pulses.
- **Overrun:** fill the ch1 FIFO and apply one more edge. Required response:
  - A single header byte 8'h81 is sent, followed by `clearoverrun`=4'b0010.
  - Subsequent frames carry header 8'h01 until the FIFO is empty.
- **Backpressure:** `txready` toggles with a random 50% duty → `txdata` is stable while `txvalid`&!`txready`, the byte sequence is identical to the `txready`=1 run, and no byte is duplicated or dropped.
- **Reset mid-frame:** assert `rstn`=0 after the byte-3 transfer. Required response:
  - All outputs are 0 within the reset.
  - After release, the full frame is re-sent starting from the header.
  - Exactly one `unload` pulse follows.
- **Idle and stale attention:** drain the last word → no spurious second frame during HOLD; `busy`=0 and `txvalid`=0 thereafter.
